// File: rtl/nr_fetch_pkg.sv
// nr_fetch_pkg: shared types, field positions and widths for the fetch stage.
package nr_fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W = 8;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RC_HI = 3;
  localparam int RC_LO = 0;
  localparam logic [3:0] HALT_OP_DEF = 4'hF;
  typedef enum logic [2:0] {IDLE, REQ_HI, REQ_LO, HOLD, HALT} state_t;
endpackage

// File: rtl/nr_fetch_if.sv
// nr_fetch_if: instruction-memory port plus the fetch-to-execute handshake.
interface nr_fetch_if;
  import nr_fetch_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_rd;
  logic [7:0] imem_data;
  logic ins_valid;
  logic ins_ready;
  logic [3:0] opcode;
  logic [3:0] rf_adr0;
  logic [3:0] rf_adr1;
  logic [3:0] rf_adr2;
  logic [ADDR_W-1:0] ins_pc;
  logic halted;
  modport master (
    output imem_addr, imem_rd, ins_valid, opcode, rf_adr0, rf_adr1, rf_adr2, ins_pc, halted,
    input imem_data, ins_ready
  );
  modport slave (
    input imem_addr, imem_rd, ins_valid, opcode, rf_adr0, rf_adr1, rf_adr2, ins_pc, halted,
    output imem_data, ins_ready
  );
endinterface

// File: rtl/nr_instr_split.sv
// nr_instr_split: splits a 16-bit instruction word into opcode and register addresses.
module nr_instr_split
  import nr_fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] word,
  output logic [3:0]         opcode,
  output logic [3:0]         rf_adr0,
  output logic [3:0]         rf_adr1,
  output logic [3:0]         rf_adr2
);
  assign opcode  = word[OP_HI:OP_LO];
  assign rf_adr0 = word[RA_HI:RA_LO];
  assign rf_adr1 = word[RB_HI:RB_LO];
  assign rf_adr2 = word[RC_HI:RC_LO];
endmodule

// File: rtl/nr_fetch_unit.sv
// nr_fetch_unit: two-byte instruction fetch FSM with PC, redirect and halt.
module nr_fetch_unit
  import nr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [3:0]        HALT_OP  = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  nr_fetch_if.master        bus
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [7:0] hi;
  logic [INSTR_W-1:0] word;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) state <= IDLE;
    else state <= state_n;
  // redirect overrides every state, including an accepting HOLD cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = en ? REQ_HI : IDLE;
      REQ_HI:  state_n = REQ_LO;
      REQ_LO:  state_n = HOLD;
      HOLD:    state_n = !bus.ins_ready ? HOLD : bus.opcode == HALT_OP ? HALT : en ? REQ_HI : IDLE;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
    if (redirect) state_n = en ? REQ_HI : IDLE;
  end
  always_comb begin
    bus.imem_rd   = state == REQ_HI || state == REQ_LO;
    bus.imem_addr = state == REQ_HI ? pc : state == REQ_LO ? pc + 8'd1 : '0;
    bus.ins_valid = state == HOLD;
    bus.halted    = state == HALT;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      pc         <= RESET_PC;
      hi         <= '0;
      word       <= '0;
      bus.ins_pc <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else begin
      hi <= state == REQ_HI ? bus.imem_data : hi;
      if (state == REQ_LO) begin
        word       <= {hi, bus.imem_data};
        bus.ins_pc <= pc;
      end
      pc <= state == HOLD && bus.ins_ready ? pc + 8'd2 : pc;
    end
  nr_instr_split u_split (
    .word    (word),
    .opcode  (bus.opcode),
    .rf_adr0 (bus.rf_adr0),
    .rf_adr1 (bus.rf_adr1),
    .rf_adr2 (bus.rf_adr2)
  );
endmodule

// File: doc/nr_fetch_unit.md
Name: nr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 8-bit instruction memory and the 16-entry register bank.
- Drives the instruction-memory read address and read enable, and assembles two consecutive bytes into one 16-bit instruction.
- Presents the decoded opcode and three 4-bit register-bank read addresses to the execute stage under a valid/ready handshake.
- Accepts branch redirects from execute.

Parameters:
- RESET_PC, 8'h00, PC loaded on reset.
- HALT_OP, 4'hF, opcode that stops fetching after it is accepted.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; a new fetch starts only while high.
- imem_addr  out  8  instruction-memory read address.
- imem_rd  out  1  instruction-memory read enable.
- imem_data  in  8  byte read from imem_addr; valid at the rising edge ending the cycle in which the address was held.
- redirect  in  1  branch taken; load redirect_pc.
- redirect_pc  in  8  branch target byte address.
- ins_valid  out  1  instruction fields valid.
- ins_ready  in  1  execute accepts the instruction.
- opcode  out  4  instruction bits [15:12].
- rf_adr0  out  4  bits [11:8], register-bank read port 0.
- rf_adr1  out  4  bits [7:4], register-bank read port 1.
- rf_adr2  out  4  bits [3:0], register-bank read port 2.
- ins_pc  out  8  address of the high byte of the presented instruction.
- halted  out  1  HALT_OP accepted; fetch stopped.

Behaviour:
- Reset (clr_n low, asynchronous):
  - pc=RESET_PC, state=IDLE.
  - ins_valid=0, imem_rd=0, imem_addr=0, halted=0.
  - opcode, rf_adr0, rf_adr1, rf_adr2 and ins_pc all 0.
  - Reset mid-fetch discards the partial instruction.
- Instruction format: first byte at pc is the high byte [15:8]; byte at pc+1 is the low byte [7:0].
- States: IDLE, REQ_HI, REQ_LO, HOLD, HALT.
  - IDLE: imem_rd=0. If en, next state REQ_HI.
  - REQ_HI: imem_addr=pc, imem_rd=1. At the ending edge, capture imem_data into hi, then go to REQ_LO.
  - REQ_LO: imem_addr=pc+1 (mod 256; pc=8'hFF reads 8'h00), imem_rd=1. At the ending edge, capture lo, load the output fields, ins_pc=pc, set ins_valid, go to HOLD.
  - HOLD: ins_valid=1, imem_rd=0; all fields held stable until accepted.
    - On an edge with ins_ready=1, the transfer completes and pc<=pc+2 (mod 256).
    - If opcode==HALT_OP, go to HALT and set halted=1.
    - Otherwise go to REQ_HI if en, else IDLE.
    - ins_valid falls on the accepting edge unless a new instruction is loaded at the same edge (not possible in this design).
  - HALT: imem_rd=0, ins_valid=0. Left only by reset or redirect.
- Latency and throughput: with en=1 and ins_ready=1, ins_valid rises 2 cycles after leaving IDLE. One instruction completes every 3 cycles.
- en low during REQ_HI/REQ_LO: the current instruction completes; no new fetch starts after acceptance.
- Redirect has highest priority, in any state:
  - pc<=redirect_pc, halted<=0, partial bytes discarded, ins_valid<=0.
  - Next state REQ_HI if en, else IDLE.
  - Redirect and ins_ready in the same HOLD cycle: the transfer counts as accepted, then the redirect applies. HALT_OP in that transfer does not halt.
  - Odd redirect_pc is legal; no alignment is enforced.
- Output fields change only on the REQ_LO-to-HOLD edge or on reset.
- imem_rd is never high in IDLE, HOLD or HALT.

Decomposition:
- Shared package nr_fetch_pkg:
  - state enum (IDLE, REQ_HI, REQ_LO, HOLD, HALT).
  - field bit positions (OP_HI=15, OP_LO=12, RA/RB/RC ranges).
  - default HALT opcode 4'hF.
  - instruction width 16, address width 8.
- One natural sub-module, nr_instr_split: combinational split of the 16-bit word into opcode, rf_adr0, rf_adr1, rf_adr2.
- The FSM and PC live in nr_fetch_unit.

Test Plan:
- Reset then en=1, ins_ready=1, mem[0]=8'h12, mem[1]=8'h34 -> imem_addr 0 then 1; ins_valid high 2 cycles after start; opcode=1, rf_adr0=2, rf_adr1=3, rf_adr2=4, ins_pc=0; next fetch at addr 2.
- ins_ready low for 5 cycles in HOLD -> fields and ins_valid stable; imem_rd=0; pc stays 0 until the ready edge, then 2.
- Redirect to 8'hFF with mem[FF]=8'hA5, mem[00]=8'h6C -> addresses FF then 00; opcode=A, rf_adr2=C, ins_pc=FF; next pc=01.
- Redirect asserted during REQ_LO -> partial discarded; no ins_valid for the old pc; fetch restarts at redirect_pc.
- Instruction 8'hF0,8'h00 accepted -> halted=1; imem_rd stays 0 for 10 cycles; redirect to 8'h10 -> halted=0, fetch from 8'h10.
- clr_n pulsed low mid-REQ_LO -> all outputs 0 immediately (asynchronous); after release, fetch resumes from RESET_PC.
